// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg
// Shared definitions for the seven-segment display driver:
//   - active-low segment patterns {g,f,e,d,c,b,a} for decimal digits 0..9
//   - blank and underscore patterns
//   - converter FSM state type
//   - max_decimal(n): constant function returning 10^n - 1
package sevenseg_pkg;

    localparam logic [6:0] SEG_0          = 7'b1000000;
    localparam logic [6:0] SEG_1          = 7'b1111001;
    localparam logic [6:0] SEG_2          = 7'b0100100;
    localparam logic [6:0] SEG_3          = 7'b0110000;
    localparam logic [6:0] SEG_4          = 7'b0011001;
    localparam logic [6:0] SEG_5          = 7'b0010010;
    localparam logic [6:0] SEG_6          = 7'b0000010;
    localparam logic [6:0] SEG_7          = 7'b1111000;
    localparam logic [6:0] SEG_8          = 7'b0000000;
    localparam logic [6:0] SEG_9          = 7'b0010000;
    localparam logic [6:0] SEG_BLANK      = 7'h7F;
    localparam logic [6:0] SEG_UNDERSCORE = 7'b1110111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } conv_state_e;

    // Largest value representable in n decimal digits (10^n - 1).
    function automatic logic [63:0] max_decimal(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// seg_digit_decode
// Combinational decoder from one BCD digit to an active-low segment pattern.
// Ports:
//   digit    in  4  BCD digit 0..9 (10..15 render blank)
//   blank    in  1  force the digit dark (leading-zero blanking)
//   overflow in  1  value did not fit; show an underscore instead
//   seg      out 7  active-low pattern {g,f,e,d,c,b,a}
module seg_digit_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       overflow,
    output logic [6:0] seg
);

    // Overflow takes priority over blanking so every digit shows the marker.
    always_comb begin
        seg = SEG_BLANK;
        if (overflow) begin
            seg = SEG_UNDERSCORE;
        end else if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/sevenseg_display_driver.sv
// sevenseg_display_driver
// Converts a binary value to DIGITS decimal digits with an iterative
// shift-add-3 engine and scans them onto a shared active-low segment bus.
// Ports:
//   clk        in  1       system clock, rising edge
//   rst_n      in  1       asynchronous active-low reset
//   bin_value  in  BIN_W   value to display, sampled on accepted load
//   load       in  1       conversion request
//   blank_lz   in  1       blank leading zeros, sampled with bin_value
//   dp_in      in  DIGITS  decimal point per digit (bit 0 = rightmost)
//   busy       out 1       conversion in progress
//   done       out 1       one-cycle pulse when new digits are committed
//   seg        out 7       active-low segments {g,f,e,d,c,b,a}, registered
//   dp         out 1       active-low decimal point, registered
//   an         out DIGITS  active-low digit enables, registered
//   conv_state out 1       converter FSM state, for observation
//
// Handshake: load is accepted on a rising edge where load=1 and busy=0.
// busy rises from that edge and falls after the commit edge BIN_W cycles
// later; a load seen while busy=1 (including on the commit edge) is dropped,
// nothing is queued.
module sevenseg_display_driver
    import sevenseg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BIN_W-1:0]  bin_value,
    input  logic              load,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_in,
    output logic              busy,
    output logic              done,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an,
    output conv_state_e       conv_state
);

    localparam int          BCD_W     = 4 * DIGITS;
    localparam int          CNT_W     = $clog2(BIN_W + 1);
    localparam int          IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int          REF_W     = $clog2(REFRESH_DIV);
    localparam logic [63:0] MAX_VALUE = max_decimal(DIGITS);

    // ------------------------------------------------------------------
    // Converter state
    // ------------------------------------------------------------------
    conv_state_e       state, state_next;
    logic              load_accept;
    logic              commit;

    logic [BIN_W-1:0]  shift_bin;
    logic [BCD_W-1:0]  shift_bcd;
    logic [CNT_W-1:0]  iter_cnt;
    logic              pend_blank;
    logic [DIGITS-1:0] pend_dp;
    logic              pend_ovf;

    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_shifted;
    logic [BIN_W-1:0]  bin_shifted;
    logic [63:0]       bin_ext;
    logic              ovf_now;

    // Display registers: only ever written on commit.
    logic [BCD_W-1:0]  disp_bcd;
    logic              disp_blank;
    logic [DIGITS-1:0] disp_dp;
    logic              disp_ovf;

    assign busy       = (state == ST_SHIFT);
    assign conv_state = state;

    // Overflow compared in 64 bits so any BIN_W/DIGITS mix compares cleanly.
    always_comb begin
        bin_ext = 64'(bin_value);
        ovf_now = (bin_ext > MAX_VALUE);
    end

    // Add-3 correction on every nibble >= 5, then shift {bcd, bin} left.
    always_comb begin
        bcd_adj = shift_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (shift_bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = shift_bcd[i*4 +: 4] + 4'd3;
            end
        end
        bcd_shifted = {bcd_adj[BCD_W-2:0], shift_bin[BIN_W-1]};
        bin_shifted = shift_bin << 1;
    end

    always_comb begin
        state_next  = state;
        load_accept = 1'b0;
        commit      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    load_accept = 1'b1;
                    state_next  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The edge that performs the final shift also commits its result.
                if (iter_cnt == CNT_W'(1)) begin
                    commit     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_bin  <= '0;
            shift_bcd  <= '0;
            iter_cnt   <= '0;
            pend_blank <= 1'b1;
            pend_dp    <= '0;
            pend_ovf   <= 1'b0;
        end else if (load_accept) begin
            shift_bin  <= bin_value;
            shift_bcd  <= '0;
            iter_cnt   <= CNT_W'(BIN_W);
            pend_blank <= blank_lz;
            pend_dp    <= dp_in;
            pend_ovf   <= ovf_now;
        end else if (state == ST_SHIFT) begin
            shift_bin  <= bin_shifted;
            shift_bcd  <= bcd_shifted;
            iter_cnt   <= iter_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_bcd   <= '0;
            disp_blank <= 1'b1;
            disp_dp    <= '0;
            disp_ovf   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= commit;
            if (commit) begin
                disp_bcd   <= bcd_shifted;
                disp_blank <= pend_blank;
                disp_dp    <= pend_dp;
                disp_ovf   <= pend_ovf;
            end
        end
    end

    // ------------------------------------------------------------------
    // Refresh scanning
    // ------------------------------------------------------------------
    logic [REF_W-1:0] ref_cnt;
    logic [IDX_W-1:0] scan_idx;
    logic             ref_wrap;

    assign ref_wrap = (ref_cnt == REF_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt  <= '0;
            scan_idx <= '0;
        end else if (ref_wrap) begin
            ref_cnt <= '0;
            if (scan_idx == IDX_W'(DIGITS - 1)) begin
                scan_idx <= '0;
            end else begin
                scan_idx <= scan_idx + IDX_W'(1);
            end
        end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

    // Digit mux plus position of the most significant nonzero digit
    // (0 when the whole value is zero, so digit 0 always shows).
    logic [3:0]       cur_digit;
    logic             cur_dp;
    logic [IDX_W-1:0] ms_idx;
    logic             cur_blank;
    logic [6:0]       dec_seg;

    always_comb begin
        cur_digit = '0;
        cur_dp    = 1'b0;
        ms_idx    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == scan_idx) begin
                cur_digit = disp_bcd[i*4 +: 4];
                cur_dp    = disp_dp[i];
            end
            if (disp_bcd[i*4 +: 4] != 4'd0) begin
                ms_idx = IDX_W'(i);
            end
        end
        cur_blank = disp_blank && (scan_idx > ms_idx);
    end

    seg_digit_decode u_decode (
        .digit    (cur_digit),
        .blank    (cur_blank),
        .overflow (disp_ovf),
        .seg      (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            seg <= dec_seg;
            dp  <= disp_ovf ? 1'b1 : ~cur_dp;
            an  <= ~(DIGITS'(1) << scan_idx);
        end
    end

endmodule

// File: tb/tb_sevenseg_display_driver.sv
// tb_sevenseg_display_driver
// Directed bench for sevenseg_display_driver with DIGITS=4, BIN_W=14,
// REFRESH_DIV=4. Each scenario task drives stimulus and checks inline.
module tb_sevenseg_display_driver;
    import sevenseg_pkg::*;

    localparam int DIGITS      = 4;
    localparam int BIN_W       = 14;
    localparam int REFRESH_DIV = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [BIN_W-1:0]  bin_value = '0;
    logic              load = 1'b0;
    logic              blank_lz = 1'b0;
    logic [DIGITS-1:0] dp_in = '0;
    logic              busy;
    logic              done;
    logic [6:0]        seg;
    logic              dp;
    logic [DIGITS-1:0] an;
    conv_state_e       conv_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_count   = 0;

    sevenseg_display_driver #(
        .DIGITS      (DIGITS),
        .BIN_W       (BIN_W),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bin_value  (bin_value),
        .load       (load),
        .blank_lz   (blank_lz),
        .dp_in      (dp_in),
        .busy       (busy),
        .done       (done),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .conv_state (conv_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_count++;
    end

    // ---------------- driver tasks ----------------
    // Present a one-cycle load; returns at the negedge after the accepting edge.
    task automatic start_load(input logic [BIN_W-1:0] value, input logic blz,
                              input logic [DIGITS-1:0] dpv);
        @(negedge clk);
        bin_value = value;
        blank_lz  = blz;
        dp_in     = dpv;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    // Count busy cycles until idle (bounded) and the done pulses seen meanwhile.
    task automatic wait_conversion(output int busy_cycles, output int dones);
        int start_done;
        start_done  = done_count;
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) busy_cycles++;
            else break;
            @(negedge clk);
        end
        @(negedge clk);
        dones = done_count - start_done;
    endtask

    // Capture seg/dp for each digit as it is scanned; misses are counted.
    task automatic capture_frame(output logic [27:0] segs, output logic [3:0] dps,
                                 output int misses);
        logic [3:0] target;
        bit found;
        segs   = '1;
        dps    = '1;
        misses = 0;
        for (int d = 0; d < DIGITS; d++) begin
            target = ~(4'b0001 << d);
            found  = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (an === target) begin
                    segs[d*7 +: 7] = seg;
                    dps[d]         = dp;
                    found          = 1'b1;
                    break;
                end
            end
            if (!found) misses++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (seg !== 7'h7F) begin tests_failed++; $display("FAIL reset_seg: got %b expected %b", seg, 7'h7F); end
        tests_run++;
        if (dp !== 1'b1) begin tests_failed++; $display("FAIL reset_dp: got %b expected 1", dp); end
        tests_run++;
        if (an !== 4'b1111) begin tests_failed++; $display("FAIL reset_an: got %b expected 1111", an); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
        tests_run++;
        if (conv_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", conv_state, ST_IDLE); end
    endtask

    task automatic test_scan();
        logic [3:0] an_seq [5];
        logic [6:0] exp_seg;
        an_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst_n = 1'b1;
        for (int k = 0; k < 5 * REFRESH_DIV; k++) begin
            @(negedge clk);
            exp_seg = ((k / REFRESH_DIV) % DIGITS == 0) ? 7'b1000000 : 7'h7F;
            tests_run++;
            if (an !== an_seq[k / REFRESH_DIV]) begin
                tests_failed++;
                $display("FAIL scan_an[%0d]: got %b expected %b", k, an, an_seq[k / REFRESH_DIV]);
            end
            tests_run++;
            if (seg !== exp_seg) begin
                tests_failed++;
                $display("FAIL scan_seg[%0d]: got %b expected %b", k, seg, exp_seg);
            end
            tests_run++;
            if (dp !== 1'b1) begin
                tests_failed++;
                $display("FAIL scan_dp[%0d]: got %b expected 1", k, dp);
            end
        end
    endtask

    task automatic test_convert_1234();
        int bc, dn, miss;
        logic [27:0] segs;
        logic [3:0]  dps;
        start_load(14'd1234, 1'b0, 4'b0000);
        wait_conversion(bc, dn);
        tests_run++;
        if (bc !== 14) begin tests_failed++; $display("FAIL c1234_busy_cycles: got %0d expected 14", bc); end
        tests_run++;
        if (dn !== 1) begin tests_failed++; $display("FAIL c1234_done_pulses: got %0d expected 1", dn); end
        capture_frame(segs, dps, miss);
        tests_run++;
        if (miss !== 0) begin tests_failed++; $display("FAIL c1234_scan_timeout: got %0d missing digits expected 0", miss); end
        tests_run++;
        if (segs !== {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}) begin
            tests_failed++;
            $display("FAIL c1234_segs: got %h expected %h", segs, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
        end
        tests_run++;
        if (dps !== 4'b1111) begin tests_failed++; $display("FAIL c1234_dps: got %b expected 1111", dps); end
    endtask

    task automatic test_blank_dp_42();
        int bc, dn, miss;
        logic [27:0] segs;
        logic [3:0]  dps;
        start_load(14'd42, 1'b1, 4'b0010);
        wait_conversion(bc, dn);
        tests_run++;
        if (dn !== 1) begin tests_failed++; $display("FAIL c42_done_pulses: got %0d expected 1", dn); end
        capture_frame(segs, dps, miss);
        tests_run++;
        if (miss !== 0) begin tests_failed++; $display("FAIL c42_scan_timeout: got %0d missing digits expected 0", miss); end
        tests_run++;
        if (segs !== {7'h7F, 7'h7F, 7'b0011001, 7'b0100100}) begin
            tests_failed++;
            $display("FAIL c42_segs: got %h expected %h", segs, {7'h7F, 7'h7F, 7'b0011001, 7'b0100100});
        end
        tests_run++;
        if (dps !== 4'b1101) begin tests_failed++; $display("FAIL c42_dps: got %b expected 1101", dps); end
    endtask

    task automatic test_overflow();
        int bc, dn, miss;
        logic [27:0] segs;
        logic [3:0]  dps;
        start_load(14'd10000, 1'b0, 4'b1111);
        wait_conversion(bc, dn);
        capture_frame(segs, dps, miss);
        tests_run++;
        if (miss !== 0) begin tests_failed++; $display("FAIL ovf_scan_timeout: got %0d missing digits expected 0", miss); end
        tests_run++;
        if (segs !== {4{7'b1110111}}) begin tests_failed++; $display("FAIL ovf_segs: got %h expected %h", segs, {4{7'b1110111}}); end
        tests_run++;
        if (dps !== 4'b1111) begin tests_failed++; $display("FAIL ovf_dps: got %b expected 1111", dps); end

        start_load(14'd9999, 1'b0, 4'b0000);
        wait_conversion(bc, dn);
        tests_run++;
        if (bc !== 14) begin tests_failed++; $display("FAIL c9999_busy_cycles: got %0d expected 14", bc); end
        capture_frame(segs, dps, miss);
        tests_run++;
        if (segs !== {4{7'b0010000}}) begin tests_failed++; $display("FAIL c9999_segs: got %h expected %h", segs, {4{7'b0010000}}); end
        tests_run++;
        if (dps !== 4'b1111) begin tests_failed++; $display("FAIL c9999_dps: got %b expected 1111", dps); end
    endtask

    task automatic test_back_to_back();
        int bc, dn, miss, busy_seen;
        logic [27:0] segs;
        logic [3:0]  dps;
        start_load(14'd5, 1'b1, 4'b0000);
        @(negedge clk);
        bin_value = 14'd7;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
        // Two of the fourteen busy cycles have already elapsed here.
        wait_conversion(bc, dn);
        tests_run++;
        if (bc !== 12) begin tests_failed++; $display("FAIL b2b_busy_cycles: got %0d expected 12", bc); end
        tests_run++;
        if (dn !== 1) begin tests_failed++; $display("FAIL b2b_done_pulses: got %0d expected 1", dn); end
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen++;
        end
        tests_run++;
        if (busy_seen !== 0) begin tests_failed++; $display("FAIL b2b_no_requeue: got %0d busy cycles expected 0", busy_seen); end
        capture_frame(segs, dps, miss);
        tests_run++;
        if (segs !== {7'h7F, 7'h7F, 7'h7F, 7'b0010010}) begin
            tests_failed++;
            $display("FAIL b2b_segs: got %h expected %h", segs, {7'h7F, 7'h7F, 7'h7F, 7'b0010010});
        end
    endtask

    task automatic test_reset_mid();
        int start_done, miss;
        logic [27:0] segs;
        logic [3:0]  dps;
        start_done = done_count;
        start_load(14'd1234, 1'b0, 4'b0001);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        tests_run++;
        if (an !== 4'b1111) begin tests_failed++; $display("FAIL rmid_an: got %b expected 1111", an); end
        tests_run++;
        if (seg !== 7'h7F) begin tests_failed++; $display("FAIL rmid_seg: got %b expected %b", seg, 7'h7F); end
        tests_run++;
        if (dp !== 1'b1) begin tests_failed++; $display("FAIL rmid_dp: got %b expected 1", dp); end
        repeat (2) @(negedge clk);
        tests_run++;
        if (an !== 4'b1111) begin tests_failed++; $display("FAIL rmid_an_held: got %b expected 1111", an); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        tests_run++;
        if (done_count !== start_done) begin
            tests_failed++;
            $display("FAIL rmid_no_done: got %0d pulses expected 0", done_count - start_done);
        end
        capture_frame(segs, dps, miss);
        tests_run++;
        if (segs !== {7'h7F, 7'h7F, 7'h7F, 7'b1000000}) begin
            tests_failed++;
            $display("FAIL rmid_segs: got %h expected %h", segs, {7'h7F, 7'h7F, 7'h7F, 7'b1000000});
        end
        tests_run++;
        if (dps !== 4'b1111) begin tests_failed++; $display("FAIL rmid_dps: got %b expected 1111", dps); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_scan();
        test_convert_1234();
        test_blank_dp_42();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
